// File: rtl/axi_stream_fifo.sv
// Single-clock first-word-fall-through FIFO with AXI4-Stream valid/ready on both sides.
// Occupancy is tracked by an explicit counter so any depth >= 2 works, not just powers of two.
module axi_stream_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_tvalid,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   output logic                  s_tready,
   output logic                  m_tvalid,
   output logic [DATA_WIDTH-1:0] m_tdata,
   input  logic                  m_tready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;

   logic full;
   logic empty;
   logic push;
   logic pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

   // Readiness comes from registered state only, so a full FIFO refuses a push
   // even when a pop happens on the same edge.
   assign s_tready = !full;
   assign m_tvalid = !empty;
   assign m_tdata  = empty ? '0 : mem[rd_ptr];

   assign push = s_tvalid && s_tready;
   assign pop  = m_tvalid && m_tready;

   // Storage is deliberately not reset; reset only makes old entries unreachable.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_tdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Directed bench for axi_stream_fifo: reset, throttled streaming, full/empty boundaries, wrap-around.
module tb_axi_stream_fifo;

   logic       clk;
   logic       rst;
   logic       s_tvalid;
   logic [7:0] s_tdata;
   logic       s_tready;
   logic       m_tvalid;
   logic [7:0] m_tdata;
   logic       m_tready;

   int checks;
   int failures;

   axi_stream_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_tvalid (s_tvalid),
      .s_tdata  (s_tdata),
      .s_tready (s_tready),
      .m_tvalid (m_tvalid),
      .m_tdata  (m_tdata),
      .m_tready (m_tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx, idle, moff, outs, exp_out, cyc, wraps;
      logic do_push, do_pop;
      logic [3:0] prev_wr;
      logic [7:0] drain_exp [16];

      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = 8'h00;
      m_tready = 1'b0;

      // ---------------- reset ----------------
      tick();
      chk("rst_init_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("rst_init_s_tready", {31'd0, s_tready}, 32'd1);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 8'h50 + 8'(i);
         tick();
      end
      chk("pre_rst_count", 32'(dut.count), 32'd5);
      chk("pre_rst_head", {24'd0, m_tdata}, 32'h50);
      s_tdata  = 8'h55;
      m_tready = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("rst_async_m_tdata", {24'd0, m_tdata}, 32'h00);
      chk("rst_async_s_tready", {31'd0, s_tready}, 32'd1);
      tick();
      chk("rst_held_count", 32'(dut.count), 32'd0);
      chk("rst_held_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      #2;
      rst = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 8'hA5;
      m_tready = 1'b0;
      tick();
      chk("post_rst_m_tvalid", {31'd0, m_tvalid}, 32'd1);
      chk("post_rst_m_tdata", {24'd0, m_tdata}, 32'hA5);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      tick();
      chk("post_rst_drained", {31'd0, m_tvalid}, 32'd0);
      m_tready = 1'b0;

      // ---------------- throttled in-order streaming ----------------
      idx = 1; idle = 0; moff = 0; outs = 0; exp_out = 1; cyc = 0;
      while (outs < 32 && cyc < 2000) begin
         s_tvalid = (idle == 0) && (idx <= 32);
         s_tdata  = 8'(idx);
         m_tready = (moff == 0);
         do_push  = s_tvalid && s_tready;
         do_pop   = m_tvalid && m_tready;
         if (do_pop) begin
            chk("stream_data", {24'd0, m_tdata}, 32'(exp_out));
            exp_out++;
         end
         tick();
         cyc++;
         if (do_push) begin
            idx++;
            idle = $urandom_range(0, 1);
         end else if (idle > 0) begin
            idle--;
         end
         if (do_pop) begin
            outs++;
            moff = $urandom_range(0, 2);
         end else if (moff > 0) begin
            moff--;
         end
      end
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      chk("stream_outs", 32'(outs), 32'd32);
      chk("stream_empty", {31'd0, m_tvalid}, 32'd0);

      // ---------------- fill to full ----------------
      for (int i = 0; i < 16; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 8'h10 + 8'(i);
         if (i == 15) chk("fill_ready_before_16th", {31'd0, s_tready}, 32'd1);
         tick();
      end
      chk("full_s_tready", {31'd0, s_tready}, 32'd0);
      chk("full_head", {24'd0, m_tdata}, 32'h10);
      s_tdata = 8'hEE;
      tick();
      chk("full_refuse_count", 32'(dut.count), 32'd16);
      chk("full_refuse_head", {24'd0, m_tdata}, 32'h10);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      chk("full_pop_data", {24'd0, m_tdata}, 32'h10);
      tick();
      chk("after_pop_s_tready", {31'd0, s_tready}, 32'd1);
      chk("after_pop_head", {24'd0, m_tdata}, 32'h11);
      chk("after_pop_count", 32'(dut.count), 32'd15);

      // ---------------- full with simultaneous offer ----------------
      m_tready = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 8'h20;
      tick();
      chk("refull_count", 32'(dut.count), 32'd16);
      s_tdata  = 8'h77;
      m_tready = 1'b1;
      tick();
      chk("full_offer_count", 32'(dut.count), 32'd15);
      chk("full_offer_head", {24'd0, m_tdata}, 32'h12);
      m_tready = 1'b0;
      tick();
      chk("full_offer_accept", 32'(dut.count), 32'd16);
      chk("full_offer_s_tready", {31'd0, s_tready}, 32'd0);
      for (int i = 0; i < 14; i++) drain_exp[i] = 8'h12 + 8'(i);
      drain_exp[14] = 8'h20;
      drain_exp[15] = 8'h77;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_data", {24'd0, m_tdata}, {24'd0, drain_exp[i]});
         tick();
      end
      chk("drain_empty", {31'd0, m_tvalid}, 32'd0);

      // ---------------- empty boundary ----------------
      s_tvalid = 1'b1;
      s_tdata  = 8'h3C;
      m_tready = 1'b1;
      chk("empty_no_valid", {31'd0, m_tvalid}, 32'd0);
      tick();
      chk("empty_push_valid", {31'd0, m_tvalid}, 32'd1);
      chk("empty_push_data", {24'd0, m_tdata}, 32'h3C);
      chk("empty_push_count", 32'(dut.count), 32'd1);
      s_tvalid = 1'b0;
      tick();
      chk("empty_popped_valid", {31'd0, m_tvalid}, 32'd0);
      chk("empty_popped_data", {24'd0, m_tdata}, 32'h00);

      // ---------------- wrap-around at count 3 ----------------
      m_tready = 1'b0;
      wraps    = 0;
      exp_out  = 0;
      for (int i = 0; i < 40 + 3; i++) begin
         s_tvalid = (i < 40);
         s_tdata  = 8'(i);
         m_tready = (i >= 3);
         if (m_tready) begin
            chk("wrap_data", {24'd0, m_tdata}, 32'(exp_out));
            exp_out++;
         end
         prev_wr = dut.wr_ptr;
         tick();
         if (prev_wr == 4'd15 && dut.wr_ptr == 4'd0) wraps++;
         if (i >= 3 && i < 40) chk("wrap_count_held", 32'(dut.count), 32'd3);
      end
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      chk("wrap_twice", {31'd0, (wraps >= 2)}, 32'd1);
      chk("wrap_wr_ptr", 32'(dut.wr_ptr), 32'd12);
      chk("wrap_rd_ptr", 32'(dut.rd_ptr), 32'd12);
      chk("wrap_empty", {31'd0, m_tvalid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_stream_fifo.md
# axi_stream_fifo

Synchronous single-clock FIFO with AXI4-Stream-style valid/ready handshakes on both sides. It buffers up to FIFO_DEPTH words of DATA_WIDTH bits between an upstream producer (slave port) and a downstream consumer (master port). Output is first-word-fall-through. Data leaves in exactly the order it was accepted, with no loss or duplication under arbitrary throttling on either side.

## Interface
- DATA_WIDTH, default 8: width of s_tdata and m_tdata in bits.
- FIFO_DEPTH, default 16: number of storage entries. Any integer ≥ 2 is legal; power of two is not required.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous and active-low. rst = 0 resets immediately; release is sampled on clk.
- s_tvalid, input, 1: upstream word on s_tdata is valid.
- s_tdata, input, DATA_WIDTH: upstream data.
- s_tready, output, 1: FIFO can accept a word this cycle.
- m_tvalid, output, 1: m_tdata holds the oldest stored word.
- m_tdata, output, DATA_WIDTH: downstream data (oldest entry).
- m_tready, input, 1: downstream accepts m_tdata this cycle.

## Operation
- State:
  - storage array of FIFO_DEPTH × DATA_WIDTH;
  - write pointer and read pointer, each 0..FIFO_DEPTH-1;
  - occupancy count, 0..FIFO_DEPTH, width $clog2(FIFO_DEPTH+1).
- Derived flags: full = (count == FIFO_DEPTH); empty = (count == 0).
- Outputs:
  - s_tready = !full;
  - m_tvalid = !empty;
  - m_tdata = mem[rd_ptr] when !empty, else all zeros.
- Push occurs when s_tvalid && s_tready at a rising edge. The word is written to mem[wr_ptr] and wr_ptr advances.
- Pop occurs when m_tvalid && m_tready at a rising edge. rd_ptr advances.
- Pointer wrap: a pointer at FIFO_DEPTH-1 advances to 0.
- Count update:
  - push only: +1;
  - pop only: −1;
  - push and pop together, or neither: unchanged.
- s_tready depends only on registered state, never on m_tready. Consequently, when full, a push is refused even if a pop happens in the same cycle.
- When empty, m_tready is ignored and no pop occurs.
- s_tdata is ignored when no push occurs.
- On rst = 0, asynchronously:
  - wr_ptr, rd_ptr and count go to 0;
  - m_tvalid = 0, m_tdata = 0, s_tready = 1;
  - storage contents are not cleared but become unreachable;
  - any words in flight are discarded.
- While rst is low, no push or pop takes effect, regardless of s_tvalid or m_tready.

## Timing
- Write-to-read latency is one cycle. A word pushed at edge N drives m_tvalid = 1 and appears on m_tdata immediately after edge N, so it is poppable at edge N+1.
- Full latency: s_tready drops immediately after the edge that makes count equal FIFO_DEPTH. It rises after the first edge that pops with no simultaneous push.
- Handshake rules (AXI-Stream):
  - A transfer is any edge where valid && ready.
  - The producer holds s_tdata stable while s_tvalid = 1 and s_tready = 0.
  - The FIFO holds m_tvalid = 1 and m_tdata stable until popped.
- Simultaneous push and pop on a single-entry FIFO (count = 1):
  - the old word pops and the new word becomes head;
  - m_tvalid stays 1;
  - m_tdata shows the new word after the edge.
- Maximum throughput is one transfer per cycle on each side simultaneously when 0 < count < FIFO_DEPTH.

## Test plan
- Reset:
  - assert rst = 0 mid-transfer with 5 words stored;
  - required: m_tvalid = 0, m_tdata = 0 and s_tready = 1 immediately;
  - after release, the first push of 0xA5 appears on m_tdata one cycle later.
- In-order streaming with throttling:
  - push 0x01..0x20 with random 0–1 idle cycles between words;
  - pop with m_tready random 0–2 cycles off;
  - required: 32 outputs equal 0x01..0x20 in order, no gaps and no repeats.
- Fill to full:
  - with m_tready = 0, push 16 words 0x10..0x1F;
  - required: s_tready = 0 after the 16th push, and a 17th offered word 0xEE is not accepted;
  - one pop yields 0x10 and s_tready returns to 1.
- Full with simultaneous offer:
  - with count = 16, s_tvalid = 1 and m_tready = 1 for one cycle;
  - required: pop only, count 15, then the offered word is accepted on the next edge.
- Empty boundary:
  - with count = 0, m_tready = 1 and s_tvalid = 1 with 0x3C;
  - required: no pop that edge; m_tvalid = 1 and m_tdata = 0x3C after it; popped next edge, then m_tvalid = 0.
- Wrap-around:
  - sustain simultaneous push/pop for 40 words (0x00..0x27) with count held at 3;
  - required: pointers wrap at least twice and the output sequence matches the input exactly.
